eeprom_dpram: RTL and testbench

//  Asymmetric true dual-port block RAM used as the GBA cartridge EEPROM backing store.

---
 rtl/eeprom_dpram.sv | 66 ++++++
 tb/tb_eeprom_dpram.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_dpram.sv
// Asymmetric dual-port RAM backing the GBA cartridge EEPROM: narrow port A
// (serial engine), wide port B (save/load path), one shared bit array.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset (outputs only)
//   addr_a/din_a/we_a/re_a : narrow port, dout_a registered read data
//   addr_b/din_b/we_b/re_b : wide port,   dout_b registered read data
module eeprom_dpram #(
  parameter int DW_A = 1,
  parameter int AW_A = 16,
  parameter int DW_B = 8,
  parameter int AW_B = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW_A-1:0] addr_a,
  input  logic [DW_A-1:0] din_a,
  input  logic            we_a,
  input  logic            re_a,
  output logic [DW_A-1:0] dout_a,
  input  logic [AW_B-1:0] addr_b,
  input  logic [DW_B-1:0] din_b,
  input  logic            we_b,
  input  logic            re_b,
  output logic [DW_B-1:0] dout_b
);

  localparam int R     = DW_B / DW_A;
  localparam int LR    = $clog2(R);
  localparam int LA    = $clog2(DW_A);
  localparam int LB    = $clog2(DW_B);
  localparam int DEPTH = 2 ** AW_B;

  // Erased EEPROM reads as all ones.
  logic [DW_B-1:0] mem [DEPTH] = '{default: '1};

  // Port A address split into wide word index and bit offset inside it.
  logic [AW_B-1:0] word_a;
  logic [LB-1:0]   off_a;

  assign word_a = AW_B'(addr_a >> LR);
  assign off_a  = LB'(addr_a << LA);

  // Port A write is issued after port B so it wins on overlapping bits,
  // while B's other bits in the same word still land.
  always_ff @(posedge clk) begin
    if (we_b)
      mem[addr_b] <= din_b;
    if (we_a)
      mem[word_a][off_a +: DW_A] <= din_a;
  end

  // Reads sample the array before this edge's writes land (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      if (re_a)
        dout_a <= mem[word_a][off_a +: DW_A];
      if (re_b)
        dout_b <= mem[addr_b];
    end
  end

endmodule

// File: tb/tb_eeprom_dpram.sv
// Bench for eeprom_dpram: bit-array reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_eeprom_dpram;

  logic        clk;
  logic        rst;
  logic [15:0] addr_a;
  logic [0:0]  din_a;
  logic        we_a;
  logic        re_a;
  logic [0:0]  dout_a;
  logic [12:0] addr_b;
  logic [7:0]  din_b;
  logic        we_b;
  logic        re_b;
  logic [7:0]  dout_b;

  int checks = 0;
  int errors = 0;

  eeprom_dpram dut (
    .clk(clk), .rst(rst),
    .addr_a(addr_a), .din_a(din_a), .we_a(we_a), .re_a(re_a),
    .dout_a(dout_a),
    .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .re_b(re_b),
    .dout_b(dout_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: flat array of 65536 bits, byte n = bits 8n..8n+7.
  bit       mb [65536];
  logic     ea;
  logic [7:0] eb;
  bit       chk_en = 1'b0;

  initial foreach (mb[i]) mb[i] = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      ea = 1'b0;
      eb = 8'h00;
    end else begin
      if (re_a) ea = mb[int'(addr_a)];
      if (re_b)
        for (int i = 0; i < 8; i++)
          eb[i] = mb[int'(addr_b) * 8 + i];
    end
    if (we_b)
      for (int i = 0; i < 8; i++)
        mb[int'(addr_b) * 8 + i] = din_b[i];
    if (we_a) mb[int'(addr_a)] = din_a[0];
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dout_a !== ea) begin
        errors++;
        $display("FAIL model_a t=%0t got=%0b exp=%0b", $time, dout_a, ea);
      end
      checks++;
      if (dout_b !== eb) begin
        errors++;
        $display("FAIL model_b t=%0t got=%02h exp=%02h", $time, dout_b, eb);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", name, got, exp);
    end
  endtask

  task automatic idle();
    we_a = 1'b0; re_a = 1'b0; din_a = 1'b0;
    we_b = 1'b0; re_b = 1'b0; din_b = 8'h00;
  endtask

  logic [7:0] pat;

  initial begin
    rst = 1'b1;
    addr_a = '0;
    addr_b = '0;
    idle();

    // 1: reset then first read of erased array
    cyc();
    cyc();
    lit("t1_rst_a", {7'd0, dout_a}, 8'h00);
    lit("t1_rst_b", dout_b, 8'h00);
    rst = 1'b0;
    re_a = 1'b1;
    addr_a = 16'h1234;
    cyc();
    lit("t1_erased", {7'd0, dout_a}, 8'h01);

    // 2: byte write on B, bitwise readback on A
    re_a = 1'b0;
    we_b = 1'b1; addr_b = 13'h0010; din_b = 8'hA5;
    cyc();
    we_b = 1'b0;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      re_a = 1'b1;
      addr_a = 16'h0080 + 16'(i);
      cyc();
      lit($sformatf("t2_bit%0d", i), {7'd0, dout_a}, {7'd0, pat[i]});
    end
    re_a = 1'b0;

    // 3: bitwise write on A, byte readback on B
    pat = 8'b1000_0011;
    for (int i = 0; i < 8; i++) begin
      we_a = 1'b1;
      addr_a = 16'h0100 + 16'(i);
      din_a = pat[i];
      cyc();
    end
    we_a = 1'b0;
    re_b = 1'b1; addr_b = 13'h0020;
    cyc();
    lit("t3_byte", dout_b, 8'h83);
    re_b = 1'b0;

    // 4: read-first on same-port read during write
    addr_a = 16'h1234;
    we_a = 1'b1; re_a = 1'b1; din_a = 1'b0;
    cyc();
    lit("t4_old", {7'd0, dout_a}, 8'h01);
    we_a = 1'b0;
    cyc();
    lit("t4_new", {7'd0, dout_a}, 8'h00);
    re_a = 1'b0;

    // 5: write/write collision, A wins on its bit
    we_a = 1'b1; addr_a = 16'h0008; din_a = 1'b0;
    we_b = 1'b1; addr_b = 13'h0001; din_b = 8'hFF;
    cyc();
    idle();
    re_b = 1'b1; addr_b = 13'h0001;
    cyc();
    lit("t5_coll", dout_b, 8'hFE);
    re_b = 1'b0;

    // 6: hold with re_a=0, then reset mid-stream keeps array
    for (int i = 0; i < 3; i++) begin
      addr_a = 16'h0080 + 16'(i);
      cyc();
      lit($sformatf("t6_hold%0d", i), {7'd0, dout_a}, 8'h00);
    end
    rst = 1'b1;
    re_b = 1'b1; addr_b = 13'h0010;
    we_b = 1'b1; din_b = 8'h3C;
    addr_a = 16'h0180;
    cyc();
    lit("t6_rst_b", dout_b, 8'h00);
    lit("t6_rst_a", {7'd0, dout_a}, 8'h00);
    rst = 1'b0;
    we_b = 1'b0;
    cyc();
    lit("t6_keep", dout_b, 8'h3C);
    addr_b = 13'h0020;
    cyc();
    lit("t6_keep2", dout_b, 8'h83);
    idle();

    // Random traffic, mostly in a small window to force collisions.
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(63) == 0);
      we_a = $urandom_range(1);
      re_a = $urandom_range(1);
      we_b = ($urandom_range(3) == 0);
      re_b = $urandom_range(1);
      din_a = 1'($urandom);
      din_b = 8'($urandom);
      if ($urandom_range(3) == 0) begin
        addr_a = 16'($urandom);
        addr_b = 13'($urandom);
      end else begin
        addr_a = 16'($urandom_range(127));
        addr_b = 13'($urandom_range(15));
      end
      cyc();
    end
    idle();
    rst = 1'b0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
